// File: rtl/router_pkg.sv
// Shared types and header-field constants for the router source-port receiver.
package router_pkg;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int CNT_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam logic [HDR_ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    CHECK   = 2'd3
  } rx_state_e;

  function automatic logic [CNT_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes; flags a mismatch against the received parity byte.
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_acc_en,
  input  logic [DATA_W-1:0] i_din,
  input  logic [DATA_W-1:0] i_cmp_byte,
  output logic              o_mismatch
);

  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_din;
    end else if (i_acc_en) begin
      r_acc <= r_acc ^ i_din;
    end
  end

  assign o_mismatch = (r_acc != i_cmp_byte);

endmodule

// File: rtl/router_pkt_rx.sv
// Router 1x3 source-port packet receiver: header decode, FIFO steering, busy back-pressure, parity check.
// Optional statistics counters (pkt_cnt/err_cnt) are built when ROUTER_RX_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a header byte (pkt_valid high)
// PAYLOAD | receiving payload bytes; pkt_valid low is a gap
// PARITY  | next byte is the parity byte, taken regardless of pkt_valid
// CHECK   | one cycle: compare parity, update error, source held off by busy
module router_pkt_rx
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_DEST = 3
`ifdef ROUTER_RX_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pkt_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic [NUM_DEST-1:0] write_enb,
  output logic [DATA_W-1:0]   data_out,
  output logic                busy,
  output logic                error
`ifdef ROUTER_RX_STATS_EN
  , output logic [STAT_W-1:0] pkt_cnt
  , output logic [STAT_W-1:0] err_cnt
`endif
);

  localparam int ADDR_SPAN = 1 << HDR_ADDR_W;

  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [HDR_ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]      r_par_byte;
  logic                   r_error;

  logic                   w_pending;
  logic [HDR_ADDR_W-1:0]  w_tgt;
  logic                   w_tgt_valid;
  logic                   w_accept;
  logic                   w_mismatch;
  logic                   w_addr_ok;
  logic                   w_err_now;
  logic [ADDR_SPAN-1:0]   w_full_pad;

  // Zero-extend so an invalid address can never select a full flag.
  assign w_full_pad = ADDR_SPAN'(fifo_full);
  assign data_out   = data_in;
  assign error      = r_error;
  assign w_addr_ok  = (r_addr != INVALID_ADDR) && (int'(r_addr) < NUM_DEST);
  assign w_err_now  = w_mismatch || !w_addr_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (hdr_len(data_in) == '0) ? PARITY : PAYLOAD;
      PAYLOAD: if (w_accept && r_cnt == CNT_W'(1)) w_state_nxt = PARITY;
      PARITY:  if (w_accept) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pending   = 1'b0;
    w_tgt       = r_addr;
    w_tgt_valid = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    write_enb   = '0;
    case (r_state)
      IDLE: begin
        w_pending = pkt_valid;
        w_tgt     = hdr_addr(data_in);
      end
      PAYLOAD: w_pending = pkt_valid;
      PARITY:  w_pending = 1'b1;
      default: w_pending = 1'b0;
    endcase
    w_tgt_valid = (w_tgt != INVALID_ADDR) && (int'(w_tgt) < NUM_DEST);
    if (!reset) begin
      busy     = (r_state == CHECK) || (w_pending && w_tgt_valid && w_full_pad[w_tgt]);
      w_accept = w_pending && !busy;
    end
    for (int i = 0; i < NUM_DEST; i++) begin
      write_enb[i] = w_accept && w_tgt_valid && (int'(w_tgt) == i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_par_byte <= '0;
      r_error    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_addr  <= hdr_addr(data_in);
        r_cnt   <= hdr_len(data_in);
        r_error <= 1'b0;
      end else if (r_state == PAYLOAD && w_accept) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == PARITY && w_accept) begin
        r_par_byte <= data_in;
      end
      if (r_state == CHECK) begin
        r_error <= w_err_now;
      end
    end
  end

  router_parity_acc #(.DATA_W(DATA_W)) u_parity (
    .clock      (clock),
    .reset      (reset),
    .i_clr      (r_state == CHECK),
    .i_load     (r_state == IDLE && w_accept),
    .i_acc_en   (r_state == PAYLOAD && w_accept),
    .i_din      (data_in),
    .i_cmp_byte (r_par_byte),
    .o_mismatch (w_mismatch)
  );

`ifdef ROUTER_RX_STATS_EN
  logic [STAT_W-1:0] r_pkt_cnt;
  logic [STAT_W-1:0] r_err_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else if (r_state == CHECK) begin
      if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + STAT_W'(1);
      if (w_err_now && r_err_cnt != '1) r_err_cnt <= r_err_cnt + STAT_W'(1);
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_router_pkt_rx.sv
// Self-checking bench for router_pkt_rx: packet-level queue model compared every cycle plus directed literal checks.
// Define ROUTER_RX_STATS_EN for both bench and RTL to exercise the statistics counters.
module tb_router_pkt_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] write_enb;
  logic [7:0] data_out;
  logic       busy;
  logic       error;
`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  router_pkt_rx dut (
    .clock     (clock),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .fifo_full (fifo_full),
    .write_enb (write_enb),
    .data_out  (data_out),
    .busy      (busy),
    .error     (error)
`ifdef ROUTER_RX_STATS_EN
    , .pkt_cnt (pkt_cnt)
    , .err_cnt (err_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model: the bytes taken so far for the current packet decide what comes next.
  logic [7:0] q[$];
  bit         m_err   = 0;
  bit         m_check = 0;
  bit         m_acc   = 0;
  bit         run_cmp = 0;
  int         m_pkt   = 0;
  int         m_errc  = 0;
  int         wr_seen[3];

  always @(negedge clock) begin
    logic       pend;
    logic [1:0] tgt;
    logic       eb;
    logic [2:0] ew;
    int         len;
    pend = 0; tgt = 2'd0; eb = 0; ew = 3'b000; m_acc = 0;
    if (run_cmp) begin
      if (!reset) begin
        if (m_check) begin
          eb = 1;
        end else begin
          if (q.size() == 0) begin
            pend = pkt_valid;
            tgt  = data_in[1:0];
          end else begin
            len  = int'(q[0][7:2]);
            pend = (q.size() < len + 1) ? pkt_valid : 1'b1;
            tgt  = q[0][1:0];
          end
          eb    = pend && (tgt != 2'd3) && fifo_full[tgt];
          m_acc = pend && !eb;
          if (m_acc && tgt != 2'd3) ew = 3'(1 << tgt);
        end
      end
      chk("busy", 32'(busy), 32'(eb));
      chk("write_enb", 32'(write_enb), 32'(ew));
      chk("data_out", 32'(data_out), 32'(data_in));
      chk("error", 32'(error), 32'(m_err));
`ifdef ROUTER_RX_STATS_EN
      chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
      chk("err_cnt", 32'(err_cnt), 32'(m_errc));
`endif
      for (int i = 0; i < 3; i++) if (write_enb[i] === 1'b1) wr_seen[i]++;
    end
  end

  always @(posedge clock) begin
    logic [7:0] x;
    bit         e;
    if (reset) begin
      q.delete(); m_err = 0; m_check = 0; m_pkt = 0; m_errc = 0;
    end else if (m_check) begin
      x = 8'h00;
      for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
      e = (x != q[q.size()-1]) || (q[0][1:0] == 2'd3);
      m_err = e;
      if (m_pkt != 65535) m_pkt++;
      if (e && m_errc != 65535) m_errc++;
      q.delete();
      m_check = 0;
    end else if (m_acc) begin
      if (q.size() == 0) m_err = 0;
      q.push_back(data_in);
      if (q.size() == int'(q[0][7:2]) + 2) m_check = 1;
    end
  end

  task automatic send(input logic v, input logic [7:0] d);
    int k;
    pkt_valid = v;
    data_in   = d;
    k = 0;
    @(negedge clock);
    while (busy && k < 40) begin
      k++;
      @(negedge clock);
    end
    if (k >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: byte %0h still busy after %0d cycles", d, k);
    end
    @(posedge clock); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    pkt_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr_seen();
    for (int i = 0; i < 3; i++) wr_seen[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
    clr_seen();
    @(posedge clock); #1;
    run_cmp = 1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_we", 32'(write_enb), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // 1: good packet to dest 1
    clr_seen();
    send(1, 8'h0D); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(0, 8'h0D);
    idle(2);
    chk("t1_wr1", 32'(wr_seen[1]), 32'd5);
    chk("t1_wr_other", 32'(wr_seen[0] + wr_seen[2]), 32'd0);
    chk("t1_error", 32'(error), 32'd0);

    // 2: bad parity; error holds until the next header
    clr_seen();
    send(1, 8'h0D); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(0, 8'h0C);
    idle(3);
    chk("t2_wr1", 32'(wr_seen[1]), 32'd5);
    chk("t2_error", 32'(error), 32'd1);

    // 3: dest 2 full for three cycles, then a payload gap
    clr_seen();
    pkt_valid = 1'b1; data_in = 8'h0A; fifo_full = 3'b100;
    repeat (3) begin
      @(negedge clock);
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_we", 32'(write_enb), 32'd0);
      chk("t3_err_held", 32'(error), 32'd1);
      @(posedge clock); #1;
    end
    fifo_full = 3'b000;
    send(1, 8'h0A); send(1, 8'h55); idle(1); send(1, 8'hAA); send(0, 8'hF5);
    idle(2);
    chk("t3_wr2", 32'(wr_seen[2]), 32'd4);
    chk("t3_error", 32'(error), 32'd0);

    // 4: invalid address, zero-length packet
    clr_seen();
    send(1, 8'h03); send(0, 8'h03);
    idle(2);
    chk("t4_wr_none", 32'(wr_seen[0] + wr_seen[1] + wr_seen[2]), 32'd0);
    chk("t4_error", 32'(error), 32'd1);

    // 5: reset mid-packet, then a fresh packet
    send(1, 8'h14); send(1, 8'h01); send(1, 8'h02);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_error", 32'(error), 32'd0);
    chk("t5_we", 32'(write_enb), 32'd0);
    @(posedge clock); #1;
    clr_seen();
    send(1, 8'h05); send(1, 8'h77); send(0, 8'h72);
    idle(2);
    chk("t5_wr1", 32'(wr_seen[1]), 32'd3);
    chk("t5_error_after", 32'(error), 32'd0);

`ifdef ROUTER_RX_STATS_EN
    // 6: statistics counters and saturation
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) begin
      send(1, 8'h0D); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(0, 8'h0D);
    end
    send(1, 8'h0D); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(0, 8'h0C);
    idle(2);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd4);
    chk("t6_err_cnt", 32'(err_cnt), 32'd1);
    force dut.r_pkt_cnt = 16'hFFFF;
    force dut.r_err_cnt = 16'hFFFF;
    m_pkt = 65535; m_errc = 65535;
    @(posedge clock); #1;
    release dut.r_pkt_cnt;
    release dut.r_err_cnt;
    send(1, 8'h0D); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(0, 8'h0C);
    idle(2);
    chk("t6_pkt_sat", 32'(pkt_cnt), 32'hFFFF);
    chk("t6_err_sat", 32'(err_cnt), 32'hFFFF);
`endif

    run_cmp = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
